gray_window_gen: RTL

Streaming front end for the Sobel edge stage. It accepts one RGB888 pixel per handshake in raster order and converts it to 8-bit luma using the team's shift-add weights. It keeps the two previous image rows in line buffers and emits one 3x3 grayscale window per interior pixel position. Each window goes to the downstream Sobel kernel on a valid/ready interface, which replaces whole-frame array processing with a line-buffered pipeline.

---
 rtl/gray_window_gen.sv | 97 +++++++++
 1 files changed

// File: rtl/gray_window_gen.sv
// gray_window_gen: RGB888 raster stream to 3x3 grayscale windows for the Sobel stage
// Ports: clk, rst_n (async active-low); s_valid/s_ready/s_r/s_g/s_b pixel input;
//        m_valid/m_ready/m_win (72-bit window, p00 in [71:64]) output; frame_done pulse.
// Optional GRAY_WIN_MARKERS_EN adds m_sof/m_eol window markers.
module gray_window_gen #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_r,
  input  logic [7:0]  s_g,
  input  logic [7:0]  s_b,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [71:0] m_win,
  output logic        frame_done
`ifdef GRAY_WIN_MARKERS_EN
  ,
  output logic        m_sof,
  output logic        m_eol
`endif
);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [7:0]    lb0_q [WIDTH];
  logic [7:0]    lb1_q [WIDTH];
  logic [71:0]   sh_q, sh_d, win_q, win_d;
  logic          vld_q, vld_d, fd_q, fd_d;
  logic          acc, emit, last_col, last_row;
  logic [7:0]    gray, top, mid;
`ifdef GRAY_WIN_MARKERS_EN
  logic          sof_q, sof_d, eol_q, eol_d;
  assign m_sof = sof_q;
  assign m_eol = eol_q;
`endif
  assign s_ready    = !vld_q || m_ready;
  assign m_valid    = vld_q;
  assign m_win      = win_q;
  assign frame_done = fd_q;
  always_comb begin
    acc      = s_valid && s_ready;
    gray     = (s_r >> 2) + (s_r >> 5) + (s_g >> 1) + (s_g >> 4) + (s_b >> 4) + (s_b >> 5);
    top      = lb1_q[col_q];
    mid      = lb0_q[col_q];
    last_col = col_q == CW'(WIDTH - 1);
    last_row = row_q == RW'(HEIGHT - 1);
    emit     = acc && row_q >= RW'(2) && col_q >= CW'(2);
    sh_d     = acc ? {sh_q[63:48], top, sh_q[39:24], mid, sh_q[15:0], gray} : sh_q;
    col_d    = acc ? (last_col ? '0 : col_q + CW'(1)) : col_q;
    row_d    = acc && last_col ? (last_row ? '0 : row_q + RW'(1)) : row_q;
    // an accept implies the held window was free or consumed, so only a stall keeps it
    vld_d    = emit || (vld_q && !m_ready);
    win_d    = emit ? sh_d : win_q;
    fd_d     = acc && last_col && last_row;
`ifdef GRAY_WIN_MARKERS_EN
    sof_d    = emit ? (row_q == RW'(2) && col_q == CW'(2)) : sof_q;
    eol_d    = emit ? last_col : eol_q;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      sh_q  <= '0;
      win_q <= '0;
      vld_q <= 1'b0;
      fd_q  <= 1'b0;
`ifdef GRAY_WIN_MARKERS_EN
      sof_q <= 1'b0;
      eol_q <= 1'b0;
`endif
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      sh_q  <= sh_d;
      win_q <= win_d;
      vld_q <= vld_d;
      fd_q  <= fd_d;
`ifdef GRAY_WIN_MARKERS_EN
      sof_q <= sof_d;
      eol_q <= eol_d;
`endif
    end
  end
  // line buffers carry no reset: rows 0 and 1 rewrite them before any window reads them
  always_ff @(posedge clk) begin
    if (acc) begin
      lb1_q[col_q] <= mid;
      lb0_q[col_q] <= gray;
    end
  end
endmodule
